// File: rtl/z16_pkg.sv
// Z16 shared ISA constants and decoded-control bundle.
// Imported by the decode stage and its combinational decoder.
package z16_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SLL  = 4'h5;
  localparam logic [3:0] OP_SRL  = 4'h6;
  localparam logic [3:0] OP_SRA  = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_LD   = 4'h9;
  localparam logic [3:0] OP_LI   = 4'hA;
  localparam logic [3:0] OP_ST   = 4'hB;
  localparam logic [3:0] OP_BEQ  = 4'hC;
  localparam logic [3:0] OP_JAL  = 4'hD;

  localparam logic [3:0] ALU_ADD   = 4'h0;
  localparam logic [3:0] ALU_SUB   = 4'h1;
  localparam logic [3:0] ALU_AND   = 4'h2;
  localparam logic [3:0] ALU_OR    = 4'h3;
  localparam logic [3:0] ALU_XOR   = 4'h4;
  localparam logic [3:0] ALU_SLL   = 4'h5;
  localparam logic [3:0] ALU_SRL   = 4'h6;
  localparam logic [3:0] ALU_SRA   = 4'h7;
  localparam logic [3:0] ALU_PASSB = 4'h8;

  // imm is kept as 8 signed bits; widened to XLEN at the stage output
  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [7:0] imm;
    logic       rd_we;
    logic       mem_we;
    logic       mem_re;
    logic [3:0] alu_ctrl;
    logic       alu_src_imm;
    logic       branch;
    logic       jump;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/z16_decode_comb.sv
// Pure combinational Z16 instruction decoder.
// Ports: instr_i -> ctrl_o (control bundle), src_o {rd-as-src, rs1, rs2} reads.
module z16_decode_comb
  import z16_pkg::*;
(
  input  logic [15:0] instr_i,
  output ctrl_t       ctrl_o,
  output logic [2:0]  src_o
);

  logic [7:0] imm4;
  logic [7:0] imm8;

  assign imm4 = {{4{instr_i[15]}}, instr_i[15:12]};
  assign imm8 = instr_i[15:8];

  always_comb begin
    ctrl_o        = '0;
    src_o         = 3'b000;
    ctrl_o.opcode = instr_i[3:0];
    ctrl_o.rd     = instr_i[7:4];
    ctrl_o.rs1    = instr_i[11:8];
    ctrl_o.rs2    = instr_i[15:12];
    if (!instr_i[3]) begin
      ctrl_o.rd_we    = 1'b1;
      ctrl_o.alu_ctrl = instr_i[3:0];
      src_o           = 3'b011;
    end else begin
      case (instr_i[3:0])
        OP_ADDI: begin
          ctrl_o.imm         = imm4;
          ctrl_o.rd_we       = 1'b1;
          ctrl_o.alu_src_imm = 1'b1;
          ctrl_o.alu_ctrl    = ALU_ADD;
          src_o              = 3'b010;
        end
        OP_LD: begin
          ctrl_o.imm      = imm4;
          ctrl_o.rd_we    = 1'b1;
          ctrl_o.mem_re   = 1'b1;
          ctrl_o.alu_ctrl = ALU_ADD;
          src_o           = 3'b010;
        end
        OP_LI: begin
          ctrl_o.imm         = imm8;
          ctrl_o.rd_we       = 1'b1;
          ctrl_o.alu_src_imm = 1'b1;
          ctrl_o.alu_ctrl    = ALU_PASSB;
        end
        OP_ST: begin
          ctrl_o.imm      = imm4;
          ctrl_o.mem_we   = 1'b1;
          ctrl_o.alu_ctrl = ALU_ADD;
          src_o           = 3'b110;
        end
        OP_BEQ: begin
          ctrl_o.imm      = imm4;
          ctrl_o.branch   = 1'b1;
          ctrl_o.alu_ctrl = ALU_SUB;
          src_o           = 3'b110;
        end
        OP_JAL: begin
          ctrl_o.imm      = imm8;
          ctrl_o.rd_we    = 1'b1;
          ctrl_o.jump     = 1'b1;
          ctrl_o.alu_ctrl = ALU_ADD;
        end
        default: ctrl_o.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/z16_decode_stage.sv
// Z16 decode stage: decoder, 2-entry skid buffer, register scoreboard.
// Ports: i_valid/o_ready in, o_valid/i_ready out, o_* controls, i_wb_* clears.
module z16_decode_stage
  import z16_pkg::*;
#(
  parameter int XLEN       = 16,
  parameter bit SKID       = 1'b1,
  parameter bit SCOREBOARD = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [15:0]     i_instr,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [3:0]      o_opcode,
  output logic [3:0]      o_rd_addr,
  output logic [3:0]      o_rs1_addr,
  output logic [3:0]      o_rs2_addr,
  output logic [XLEN-1:0] o_imm,
  output logic            o_rd_we,
  output logic            o_mem_we,
  output logic            o_mem_re,
  output logic [3:0]      o_alu_ctrl,
  output logic            o_alu_src_imm,
  output logic            o_branch,
  output logic            o_jump,
  output logic            o_illegal,
  input  logic            i_wb_valid,
  input  logic [3:0]      i_wb_addr
);

  ctrl_t       dec;
  logic [2:0]  src;
  ctrl_t       e0_q, e0_d, e1_q, e1_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] busy_q, busy_d;
  logic        hazard, space, push, pop;

  z16_decode_comb u_dec (
    .instr_i (i_instr),
    .ctrl_o  (dec),
    .src_o   (src)
  );

  assign hazard = i_valid &
    ((src[2] & busy_q[dec.rd]) |
     (src[1] & busy_q[dec.rs1]) |
     (src[0] & busy_q[dec.rs2]) |
     (dec.rd_we & busy_q[dec.rd]));

  // single-entry mode may refill in the same cycle it drains
  assign space   = SKID ? (cnt_q != 2'd2)
                        : ((cnt_q == 2'd0) | i_ready);
  assign o_ready = ~hazard & space;
  assign o_valid = (cnt_q != 2'd0);
  assign push    = i_valid & o_ready & ~i_flush;
  assign pop     = o_valid & i_ready & ~i_flush;

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    if (i_flush) begin
      e0_d  = '0;
      e1_d  = '0;
      cnt_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) e0_d = dec;
          else               e1_d = dec;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          e0_d  = e1_q;
          cnt_d = cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            e0_d = dec;
          end else begin
            e0_d = e1_q;
            e1_d = dec;
          end
        end
        default: ;
      endcase
    end
  end

  // clear first so a same-cycle set on the same register wins
  always_comb begin
    busy_d = busy_q;
    if (i_wb_valid) busy_d[i_wb_addr] = 1'b0;
    if (SCOREBOARD && push && dec.rd_we) busy_d[dec.rd] = 1'b1;
    if (i_flush) busy_d = '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      e0_q   <= '0;
      e1_q   <= '0;
      cnt_q  <= 2'd0;
      busy_q <= '0;
    end else begin
      e0_q   <= e0_d;
      e1_q   <= e1_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign o_opcode      = e0_q.opcode;
  assign o_rd_addr     = e0_q.rd;
  assign o_rs1_addr    = e0_q.rs1;
  assign o_rs2_addr    = e0_q.rs2;
  assign o_imm         = {{(XLEN-8){e0_q.imm[7]}}, e0_q.imm};
  assign o_rd_we       = e0_q.rd_we;
  assign o_mem_we      = e0_q.mem_we;
  assign o_mem_re      = e0_q.mem_re;
  assign o_alu_ctrl    = e0_q.alu_ctrl;
  assign o_alu_src_imm = e0_q.alu_src_imm;
  assign o_branch      = e0_q.branch;
  assign o_jump        = e0_q.jump;
  assign o_illegal     = e0_q.illegal;

endmodule
